// File: rtl/opb_reg_bank_pkg.sv
// Shared FSM encoding, byte-lane geometry and address arithmetic for the OPB register bank.
// Pure definitions: no latency, no backpressure.
package opb_reg_bank_pkg;
    localparam int LANE_W    = 8;
    localparam int NUM_LANES = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACK  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    function automatic logic [31:0] word_idx(input logic [31:0] addr, input logic [31:0] base);
        return (addr - base) >> 2;
    endfunction

    // be[i] enables the lane at bits [8i+7:8i]; be[3] is the OPB BE[0] lane
    function automatic logic [31:0] be_merge(input logic [31:0]          old_w,
                                             input logic [31:0]          new_w,
                                             input logic [NUM_LANES-1:0] be);
        logic [31:0] res;
        res = old_w;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (be[i]) res[i*LANE_W +: LANE_W] = new_w[i*LANE_W +: LANE_W];
        end
        return res;
    endfunction
endpackage

// File: rtl/opb_reg_bank_decode.sv
// Combinational window decode: hit, word index, mapped/error/commit flags; zero latency, no backpressure.
// OPB_REG_BANK_SHADOW_EN maps the commit word at idx == C_NUM_REGS; otherwise it decodes as an error.
module opb_reg_bank_decode
    import opb_reg_bank_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR = 32'h0100_0400,
    parameter logic [31:0] C_HIGHADDR = 32'h0100_04FF,
    parameter int          C_NUM_REGS = 8
) (
    input  logic [31:0] abus,
    input  logic        select,
    output logic        hit,
    output logic [5:0]  idx,
    output logic        valid,
    output logic        err,
    output logic        commit
);
    logic [31:0] word;

    assign hit   = select && (abus >= C_BASEADDR) && (abus <= C_HIGHADDR);
    assign word  = word_idx(abus, C_BASEADDR);
    assign idx   = word[5:0];
    assign valid = hit && (word < 32'(C_NUM_REGS));

`ifdef OPB_REG_BANK_SHADOW_EN
    assign commit = hit && (word == 32'(C_NUM_REGS));
`else
    assign commit = 1'b0;
`endif

    assign err = hit && !valid && !commit;
endmodule

// File: rtl/opb_register_bank_ppc2simulink.sv
// OPB slave bank of C_NUM_REGS control registers driving Simulink fabric; ack one cycle after hit, write visible one cycle later.
// No backpressure: every mapped hit is acked, unmapped words errAck; OPB_REG_BANK_SHADOW_EN adds shadow registers plus a commit word.
module opb_register_bank_ppc2simulink
    import opb_reg_bank_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR    = 32'h0100_0400,
    parameter logic [31:0] C_HIGHADDR    = 32'h0100_04FF,
    parameter int          C_OPB_AWIDTH  = 32,
    parameter int          C_OPB_DWIDTH  = 32,
    parameter int          C_NUM_REGS    = 8,
    parameter logic [31:0] C_RESET_VALUE = 32'h0
) (
    input  logic                     OPB_Clk,
    input  logic                     OPB_Rst_n,
    input  logic [0:C_OPB_AWIDTH-1]  OPB_ABus,
    input  logic [0:3]               OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1]  OPB_DBus,
    input  logic                     OPB_RNW,
    input  logic                     OPB_select,
    input  logic                     OPB_seqAddr,
    output logic [0:C_OPB_DWIDTH-1]  Sl_DBus,
    output logic                     Sl_xferAck,
    output logic                     Sl_errAck,
    output logic                     Sl_retry,
    output logic                     Sl_toutSup,
    output logic [C_NUM_REGS*32-1:0] user_data_out,
    output logic [C_NUM_REGS-1:0]    user_update
);
    // OPB bit 0 is the MSB, so positional assignment gives the little-endian view
    logic [31:0]          abus, wdat;
    logic [NUM_LANES-1:0] be;
    assign abus = OPB_ABus;
    assign wdat = OPB_DBus;
    assign be   = OPB_BE;

    logic       dec_hit, dec_valid, dec_err, dec_commit;
    logic [5:0] dec_idx;

    opb_reg_bank_decode #(
        .C_BASEADDR (C_BASEADDR),
        .C_HIGHADDR (C_HIGHADDR),
        .C_NUM_REGS (C_NUM_REGS)
    ) u_decode (
        .abus   (abus),
        .select (OPB_select),
        .hit    (dec_hit),
        .idx    (dec_idx),
        .valid  (dec_valid),
        .err    (dec_err),
        .commit (dec_commit)
    );

    logic [1:0]            state_q, state_d;
    logic [5:0]            idx_q, idx_d;
    logic                  rnw_q, rnw_d, valid_q, valid_d, commit_q, commit_d;
    logic [NUM_LANES-1:0]  be_q, be_d;
    logic [31:0]           dat_q, dat_d;
    logic                  xfer_q, xfer_d, err_q, err_d;
    logic [31:0]           dbus_q, dbus_d;
    logic [31:0]           live_q [C_NUM_REGS];
    logic [31:0]           live_d [C_NUM_REGS];
`ifdef OPB_REG_BANK_SHADOW_EN
    logic [31:0]           shd_q [C_NUM_REGS];
    logic [31:0]           shd_d [C_NUM_REGS];
`endif
    logic [C_NUM_REGS-1:0] upd_q, upd_d;
    logic [31:0]           rd_word;
    logic                  wr_fire, commit_fire;

    always_comb begin
        rd_word = '0;
        for (int k = 0; k < C_NUM_REGS; k++) begin
            if (dec_idx == 6'(k)) begin
`ifdef OPB_REG_BANK_SHADOW_EN
                rd_word = shd_q[k];
`else
                rd_word = live_q[k];
`endif
            end
        end
    end

    // Transfer attributes are captured at the hit so the commit does not depend on the master holding the bus
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        rnw_d    = rnw_q;
        be_d     = be_q;
        dat_d    = dat_q;
        valid_d  = valid_q;
        commit_d = commit_q;
        xfer_d   = 1'b0;
        err_d    = 1'b0;
        dbus_d   = '0;
        case (state_q)
            ST_IDLE: begin
                if (dec_hit) begin
                    state_d  = ST_ACK;
                    idx_d    = dec_idx;
                    rnw_d    = OPB_RNW;
                    be_d     = be;
                    dat_d    = wdat;
                    valid_d  = dec_valid;
                    commit_d = dec_commit;
                    xfer_d   = dec_valid || dec_commit;
                    err_d    = dec_err;
                    dbus_d   = (OPB_RNW && dec_valid) ? rd_word : '0;
                end
            end
            ST_ACK:  state_d = OPB_seqAddr ? ST_IDLE : ST_HOLD;
            ST_HOLD: if (!OPB_select) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign wr_fire     = (state_q == ST_ACK) && !rnw_q && valid_q;
    assign commit_fire = (state_q == ST_ACK) && !rnw_q && commit_q && (be_q != '0);

    always_comb begin
        live_d = live_q;
        upd_d  = '0;
`ifdef OPB_REG_BANK_SHADOW_EN
        shd_d  = shd_q;
`endif
        for (int k = 0; k < C_NUM_REGS; k++) begin
            if (wr_fire && (idx_q == 6'(k))) begin
`ifdef OPB_REG_BANK_SHADOW_EN
                shd_d[k] = be_merge(shd_q[k], dat_q, be_q);
`else
                live_d[k] = be_merge(live_q[k], dat_q, be_q);
                upd_d[k]  = (be_q != '0);
`endif
            end
        end
        if (commit_fire) begin
`ifdef OPB_REG_BANK_SHADOW_EN
            live_d = shd_q;
`endif
            upd_d = '1;
        end
    end

    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            rnw_q    <= 1'b0;
            be_q     <= '0;
            dat_q    <= '0;
            valid_q  <= 1'b0;
            commit_q <= 1'b0;
            xfer_q   <= 1'b0;
            err_q    <= 1'b0;
            dbus_q   <= '0;
            upd_q    <= '0;
            for (int k = 0; k < C_NUM_REGS; k++) begin
                live_q[k] <= C_RESET_VALUE;
`ifdef OPB_REG_BANK_SHADOW_EN
                shd_q[k]  <= C_RESET_VALUE;
`endif
            end
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            rnw_q    <= rnw_d;
            be_q     <= be_d;
            dat_q    <= dat_d;
            valid_q  <= valid_d;
            commit_q <= commit_d;
            xfer_q   <= xfer_d;
            err_q    <= err_d;
            dbus_q   <= dbus_d;
            upd_q    <= upd_d;
            live_q   <= live_d;
`ifdef OPB_REG_BANK_SHADOW_EN
            shd_q    <= shd_d;
`endif
        end
    end

    for (genvar k = 0; k < C_NUM_REGS; k++) begin : g_out
        assign user_data_out[32*k +: 32] = live_q[k];
    end

    assign user_update = upd_q;
    assign Sl_DBus     = dbus_q;
    assign Sl_xferAck  = xfer_q;
    assign Sl_errAck   = err_q;
    assign Sl_retry    = 1'b0;
    assign Sl_toutSup  = 1'b0;
endmodule

// File: tb/tb_opb_register_bank_ppc2simulink.sv
// Bench for the OPB register bank: scoreboarded bus responses plus a register model of live/shadow state.
module tb_opb_register_bank_ppc2simulink;
    localparam int          NR   = 8;
    localparam logic [31:0] BASE = 32'h0100_0400;
    localparam logic [31:0] RV   = 32'hA5A5_0000;
`ifdef OPB_REG_BANK_SHADOW_EN
    localparam bit SHADOW = 1'b1;
`else
    localparam bit SHADOW = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [0:31]    abus = '0;
    logic [0:31]    dbus_w = '0;
    logic [0:3]     be = '0;
    logic           rnw = 1'b0, sel = 1'b0, seq = 1'b0;
    logic [0:31]    sl_dbus;
    logic           xack, eack, retry, tsup;
    logic [NR*32-1:0] udo;
    logic [NR-1:0]  upd;

    always #5 clk = ~clk;

    opb_register_bank_ppc2simulink #(
        .C_BASEADDR(BASE), .C_HIGHADDR(32'h0100_04FF), .C_OPB_AWIDTH(32),
        .C_OPB_DWIDTH(32), .C_NUM_REGS(NR), .C_RESET_VALUE(RV)
    ) dut (
        .OPB_Clk(clk), .OPB_Rst_n(rst_n), .OPB_ABus(abus), .OPB_BE(be),
        .OPB_DBus(dbus_w), .OPB_RNW(rnw), .OPB_select(sel), .OPB_seqAddr(seq),
        .Sl_DBus(sl_dbus), .Sl_xferAck(xack), .Sl_errAck(eack), .Sl_retry(retry),
        .Sl_toutSup(tsup), .user_data_out(udo), .user_update(upd)
    );

    typedef struct packed {
        logic        xfer;
        logic        err;
        logic [31:0] dat;
    } rsp_t;

    rsp_t        exp_q[$];
    int          total = 0;
    int          bad = 0;
    logic [31:0] m_live[NR];
    logic [31:0] m_shd[NR];
    logic [NR*32-1:0] d0, d1;
    logic [NR-1:0]    u1, u2;

    function automatic rsp_t mk(input logic x, input logic e, input logic [31:0] d);
        rsp_t r;
        r.xfer = x;
        r.err  = e;
        r.dat  = d;
        return r;
    endfunction

    function automatic logic [31:0] m_rd(input int idx);
        return SHADOW ? m_shd[idx] : m_live[idx];
    endfunction

    task automatic model_write(input int idx, input logic [0:3] b, input logic [31:0] d,
                               output logic [NR-1:0] eu);
        logic [31:0] r;
        r = m_rd(idx);
        for (int l = 0; l < 4; l++) if (b[l]) r[31-8*l -: 8] = d[31-8*l -: 8];
        if (SHADOW) m_shd[idx] = r;
        else        m_live[idx] = r;
        eu = '0;
        if (!SHADOW && b != 4'b0000) eu[idx] = 1'b1;
    endtask

    // Drives one transfer, then pops the scoreboard entry when the response (or its absence) is seen
    task automatic xfer(input logic [31:0] a, input logic r, input logic [0:3] b,
                        input logic [31:0] wd, input string nm);
        rsp_t got, exp;
        int   lat;
        @(negedge clk);
        abus = a; rnw = r; be = b; dbus_w = wd; seq = 1'b0; sel = 1'b1;
        got = '0;
        lat = 0;
        d0  = udo;
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk); #1;
            if (xack || eack) begin
                got = mk(xack, eack, sl_dbus);
                lat = c;
                d0  = udo;
                break;
            end
        end
        @(negedge clk);
        sel = 1'b0; abus = '0; be = '0; dbus_w = '0; rnw = 1'b0;
        @(posedge clk); #1;
        u1 = upd;
        d1 = udo;
        total++;
        if ((xack | eack) !== 1'b0 || sl_dbus !== 32'h0) begin
            bad++;
            $display("FAIL %s_after_ack: ack=%b err=%b dbus=%h, required 0 0 00000000", nm, xack, eack, sl_dbus);
        end
        @(posedge clk); #1;
        u2 = upd;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL %s_scoreboard: no expected entry queued", nm);
        end else begin
            exp = exp_q.pop_front();
            if (got !== exp) begin
                bad++;
                $display("FAIL %s: xfer=%b err=%b dbus=%h, required xfer=%b err=%b dbus=%h",
                         nm, got.xfer, got.err, got.dat, exp.xfer, exp.err, exp.dat);
            end
            if (exp.xfer || exp.err) begin
                total++;
                if (lat !== 1) begin
                    bad++;
                    $display("FAIL %s_latency: ack after %0d cycles, required 1", nm, lat);
                end
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < NR; k++) begin
            total++;
            if (udo[32*k +: 32] !== RV) begin
                bad++;
                $display("FAIL reset_word%0d: got %h, required %h", k, udo[32*k +: 32], RV);
            end
        end
        total++;
        if ({xack, eack, retry, tsup} !== 4'b0 || sl_dbus !== 32'h0 || upd !== '0) begin
            bad++;
            $display("FAIL reset_outputs: ack=%b err=%b retry=%b tout=%b dbus=%h upd=%b, required all 0",
                     xack, eack, retry, tsup, sl_dbus, upd);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        total++;
        if (xack !== 1'b0 || upd !== '0 || udo[31:0] !== RV) begin
            bad++;
            $display("FAIL reset_release: ack=%b upd=%b word0=%h, required 0 0 %h", xack, upd, udo[31:0], RV);
        end
        for (int k = 0; k < NR; k++) begin
            m_live[k] = RV;
            m_shd[k]  = RV;
        end
    endtask

    task automatic test_write_full;
        logic [NR-1:0] eu;
        exp_q.push_back(mk(1'b1, 1'b0, 32'h0));
        model_write(2, 4'b1111, 32'hDEAD_BEEF, eu);
        xfer(BASE + 32'h8, 1'b0, 4'b1111, 32'hDEAD_BEEF, "wr_full");
        total++;
        if (u1 !== eu) begin bad++; $display("FAIL wr_full_update: got %b, required %b", u1, eu); end
        total++;
        if (u2 !== '0) begin bad++; $display("FAIL wr_full_update_len: got %b, required 0", u2); end
        total++;
        if (d0[95:64] !== RV) begin bad++; $display("FAIL wr_full_early: got %h during ack, required %h", d0[95:64], RV); end
        total++;
        if (d1[95:64] !== m_live[2]) begin bad++; $display("FAIL wr_full_data: got %h, required %h", d1[95:64], m_live[2]); end
    endtask

    task automatic test_write_be;
        logic [NR-1:0] eu;
        exp_q.push_back(mk(1'b1, 1'b0, 32'h0));
        model_write(2, 4'b0101, 32'h1122_3344, eu);
        xfer(BASE + 32'h8, 1'b0, 4'b0101, 32'h1122_3344, "wr_be");
        total++;
        if (u1 !== eu) begin bad++; $display("FAIL wr_be_update: got %b, required %b", u1, eu); end
        total++;
        if (d1[95:64] !== m_live[2]) begin bad++; $display("FAIL wr_be_data: got %h, required %h", d1[95:64], m_live[2]); end
        exp_q.push_back(mk(1'b1, 1'b0, 32'hDE22_BE44));
        xfer(BASE + 32'h8, 1'b1, 4'b1111, 32'h0, "rd_be");
    endtask

    task automatic test_be_zero;
        logic [NR-1:0] eu;
        exp_q.push_back(mk(1'b1, 1'b0, 32'h0));
        model_write(3, 4'b0000, 32'hFFFF_FFFF, eu);
        xfer(BASE + 32'hC, 1'b0, 4'b0000, 32'hFFFF_FFFF, "wr_be0");
        total++;
        if (u1 !== '0 || d1[127:96] !== RV) begin
            bad++;
            $display("FAIL wr_be0_nochange: upd=%b word3=%h, required 0 %h", u1, d1[127:96], RV);
        end
    endtask

    task automatic test_errors;
        exp_q.push_back(mk(1'b0, 1'b1, 32'h0));
        xfer(BASE + 32'h40, 1'b1, 4'b1111, 32'h0, "rd_unmapped");
        exp_q.push_back(mk(1'b0, 1'b0, 32'h0));
        xfer(32'h0100_0500, 1'b1, 4'b1111, 32'h0, "rd_above_window");
        exp_q.push_back(mk(1'b0, 1'b0, 32'h0));
        xfer(32'h0100_03FC, 1'b1, 4'b1111, 32'h0, "rd_below_window");
        exp_q.push_back(mk(1'b0, 1'b1, 32'h0));
        xfer(BASE + 32'hFF, 1'b1, 4'b1111, 32'h0, "rd_last_byte");
        exp_q.push_back(mk(1'b1, 1'b0, m_rd(7)));
        xfer(BASE + 32'h1F, 1'b1, 4'b1111, 32'h0, "rd_last_reg");
        exp_q.push_back(mk(1'b1, 1'b0, m_rd(2)));
        xfer(BASE + 32'h0B, 1'b1, 4'b1111, 32'h0, "rd_low_bits");
        exp_q.push_back(mk(1'b0, 1'b1, 32'h0));
        xfer(BASE + 32'h44, 1'b0, 4'b1111, 32'hFFFF_FFFF, "wr_unmapped");
        total++;
        if (u1 !== '0) begin bad++; $display("FAIL wr_unmapped_update: got %b, required 0", u1); end
        for (int k = 0; k < NR; k++) begin
            total++;
            if (d1[32*k +: 32] !== m_live[k]) begin
                bad++;
                $display("FAIL wr_unmapped_word%0d: got %h, required %h", k, d1[32*k +: 32], m_live[k]);
            end
        end
    endtask

    task automatic test_back_to_back;
        rsp_t got, exp;
        logic seen;
        exp_q.push_back(mk(1'b1, 1'b0, m_rd(0)));
        exp_q.push_back(mk(1'b1, 1'b0, m_rd(2)));
        @(negedge clk);
        abus = BASE; rnw = 1'b1; be = 4'b1111; seq = 1'b1; sel = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (xack) begin seen = 1'b1; break; end
        end
        got = mk(xack, eack, sl_dbus);
        exp = exp_q.pop_front();
        total++;
        if (!seen || got !== exp) begin
            bad++;
            $display("FAIL b2b_first: seen=%b dbus=%h, required ack with %h", seen, got.dat, exp.dat);
        end
        @(negedge clk);
        abus = BASE + 32'h8;
        @(posedge clk); #1;
        total++;
        if (xack !== 1'b0 || sl_dbus !== 32'h0) begin
            bad++;
            $display("FAIL b2b_gap: ack=%b dbus=%h, required 0 00000000", xack, sl_dbus);
        end
        @(posedge clk); #1;
        got = mk(xack, eack, sl_dbus);
        exp = exp_q.pop_front();
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL b2b_second: xfer=%b err=%b dbus=%h, required xfer=%b err=%b dbus=%h",
                     got.xfer, got.err, got.dat, exp.xfer, exp.err, exp.dat);
        end
        @(negedge clk);
        sel = 1'b0; seq = 1'b0; abus = '0; rnw = 1'b0;
        repeat (2) @(posedge clk);
    endtask

`ifdef OPB_REG_BANK_SHADOW_EN
    task automatic test_shadow;
        logic [NR-1:0] eu;
        exp_q.push_back(mk(1'b1, 1'b0, 32'h0));
        model_write(0, 4'b1111, 32'h1, eu);
        xfer(BASE, 1'b0, 4'b1111, 32'h1, "sh_wr0");
        total++;
        if (u1 !== eu || d1[31:0] !== m_live[0]) begin
            bad++;
            $display("FAIL sh_wr0_live: upd=%b word0=%h, required %b %h", u1, d1[31:0], eu, m_live[0]);
        end
        exp_q.push_back(mk(1'b1, 1'b0, 32'h0));
        model_write(1, 4'b1111, 32'h2, eu);
        xfer(BASE + 32'h4, 1'b0, 4'b1111, 32'h2, "sh_wr1");
        total++;
        if (u1 !== eu || d1[63:32] !== m_live[1]) begin
            bad++;
            $display("FAIL sh_wr1_live: upd=%b word1=%h, required %b %h", u1, d1[63:32], eu, m_live[1]);
        end
        exp_q.push_back(mk(1'b1, 1'b0, 32'h1));
        xfer(BASE, 1'b1, 4'b1111, 32'h0, "sh_rd0");
        exp_q.push_back(mk(1'b1, 1'b0, 32'h0));
        xfer(BASE + 32'h20, 1'b1, 4'b1111, 32'h0, "sh_rd_commit");
        exp_q.push_back(mk(1'b1, 1'b0, 32'h0));
        xfer(BASE + 32'h20, 1'b0, 4'b1111, 32'h0, "sh_commit");
        for (int k = 0; k < NR; k++) m_live[k] = m_shd[k];
        total++;
        if (u1 !== '1) begin bad++; $display("FAIL sh_commit_update: got %b, required all ones", u1); end
        total++;
        if (d1[31:0] !== 32'h1 || d1[63:32] !== 32'h2) begin
            bad++;
            $display("FAIL sh_commit_data: word0=%h word1=%h, required 00000001 00000002", d1[31:0], d1[63:32]);
        end
        total++;
        if (d0[31:0] !== RV || u2 !== '0) begin
            bad++;
            $display("FAIL sh_commit_timing: early word0=%h upd_next=%b, required %h 0", d0[31:0], u2, RV);
        end
    endtask
`else
    task automatic test_commit_unmapped;
        exp_q.push_back(mk(1'b0, 1'b1, 32'h0));
        xfer(BASE + 32'h20, 1'b0, 4'b1111, 32'h1234_5678, "commit_wr_unmapped");
        total++;
        if (u1 !== '0) begin bad++; $display("FAIL commit_wr_update: got %b, required 0", u1); end
        exp_q.push_back(mk(1'b0, 1'b1, 32'h0));
        xfer(BASE + 32'h20, 1'b1, 4'b1111, 32'h0, "commit_rd_unmapped");
    endtask
`endif

    task automatic test_reset_mid;
        logic seen;
        @(negedge clk);
        abus = BASE + 32'h14; rnw = 1'b0; be = 4'b1111; dbus_w = 32'h1234_5678; sel = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (xack) begin seen = 1'b1; break; end
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (!seen || xack !== 1'b0 || eack !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_ack: reached_ack=%b ack=%b err=%b, required 1 0 0", seen, xack, eack);
        end
        sel = 1'b0; abus = '0; be = '0; dbus_w = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < NR; k++) begin
            m_live[k] = RV;
            m_shd[k]  = RV;
            total++;
            if (udo[32*k +: 32] !== RV) begin
                bad++;
                $display("FAIL rst_mid_word%0d: got %h, required %h", k, udo[32*k +: 32], RV);
            end
        end
        total++;
        if (upd !== '0) begin bad++; $display("FAIL rst_mid_update: got %b, required 0", upd); end
        exp_q.push_back(mk(1'b1, 1'b0, RV));
        xfer(BASE + 32'h8, 1'b1, 4'b1111, 32'h0, "rst_mid_readback");
    endtask

    initial begin
        test_reset;
        test_write_full;
        test_write_be;
        test_be_zero;
        test_errors;
        test_back_to_back;
`ifdef OPB_REG_BANK_SHADOW_EN
        test_shadow;
`else
        test_commit_unmapped;
`endif
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end
endmodule
